// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Encodings shared by the decode, control and writeback
//                stages: writeback result source and load size codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

   // Writeback result source (code 2'b11 is unused and behaves as ALU)
   localparam logic [1:0] WB_SRC_ALU  = 2'b00;
   localparam logic [1:0] WB_SRC_MEM  = 2'b01;
   localparam logic [1:0] WB_SRC_LINK = 2'b10;

   // Load access size (code 2'b11 is unused and behaves as WORD)
   localparam logic [1:0] LOAD_BYTE = 2'b00;
   localparam logic [1:0] LOAD_HALF = 2'b01;
   localparam logic [1:0] LOAD_WORD = 2'b10;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/load_aligner.sv
`default_nettype none
// ============================================================================
//  Module      : load_aligner
//  Description : Little-endian lane selection and sign/zero extension of a
//                data-memory word for byte, halfword and word loads.
//                Purely combinational; also used by the debug memory viewer.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_aligner
   import mips_pkg::*;
#(
   parameter int NB_DATA = 32
)(
   input  logic [NB_DATA-1:0] i_word,
   input  logic [1:0]         i_addr,
   input  logic [1:0]         i_size,
   input  logic               i_unsigned,
   output logic [NB_DATA-1:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic        w_byte_sign;
   logic        w_half_sign;

   // Pick the addressed byte and halfword lanes; a[0] is ignored for halves
   always_comb begin
      w_byte = i_word[7:0];
      case (i_addr)
         2'd0:    w_byte = i_word[7:0];
         2'd1:    w_byte = i_word[15:8];
         2'd2:    w_byte = i_word[23:16];
         default: w_byte = i_word[31:24];
      endcase
      w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
   end

   assign w_byte_sign = w_byte[7]  & ~i_unsigned;
   assign w_half_sign = w_half[15] & ~i_unsigned;

   // Extend the selected lane to the datapath width
   always_comb begin
      o_data = i_word;
      case (i_size)
         LOAD_BYTE: o_data = {{(NB_DATA-8){w_byte_sign}}, w_byte};
         LOAD_HALF: o_data = {{(NB_DATA-16){w_half_sign}}, w_half};
         default:   o_data = i_word;
      endcase
   end

endmodule : load_aligner
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : writeback_stage
//  Description : Final MIPS pipeline stage. Selects the result (ALU, aligned
//                load data or link address), registers the register-bank
//                write port, latches a sticky halt flag and counts retired
//                instructions for the debug unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module writeback_stage
   import mips_pkg::*;
#(
   parameter int NB_DATA     = 32,
   parameter int NB_REGISTER = 5,
   parameter int NB_COUNT    = 32
)(
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_valid,
   input  logic                   i_instr_valid,
   input  logic                   i_reg_write,
   input  logic [1:0]             i_wb_src,
   input  logic [1:0]             i_load_size,
   input  logic                   i_load_unsigned,
   input  logic                   i_halt,
   input  logic [NB_REGISTER-1:0] i_rd_sel,
   input  logic [NB_DATA-1:0]     i_alu_result,
   input  logic [NB_DATA-1:0]     i_mem_data,
   input  logic [NB_DATA-1:0]     i_pc_next,
   output logic [NB_DATA-1:0]     o_data_reg_write,
   output logic [NB_REGISTER-1:0] o_data_reg_write_sel,
   output logic                   o_write_reg_enable,
   output logic                   o_halt,
   output logic [NB_COUNT-1:0]    o_retired_count
);

   logic [NB_DATA-1:0]     w_load_data;
   logic [NB_DATA-1:0]     w_result;
   logic                   w_write_enable;
   logic                   w_retire;

   logic [NB_DATA-1:0]     r_data;
   logic [NB_REGISTER-1:0] r_sel;
   logic                   r_write_enable;
   logic                   r_halt;
   logic [NB_COUNT-1:0]    r_count;

   load_aligner #(
      .NB_DATA (NB_DATA)
   ) u_load_aligner (
      .i_word     (i_mem_data),
      .i_addr     (i_alu_result[1:0]),
      .i_size     (i_load_size),
      .i_unsigned (i_load_unsigned),
      .o_data     (w_load_data)
   );

   // Result source mux; the unused source code falls back to the ALU result
   always_comb begin
      w_result = i_alu_result;
      case (i_wb_src)
         WB_SRC_MEM:  w_result = w_load_data;
         WB_SRC_LINK: w_result = i_pc_next;
         default:     w_result = i_alu_result;
      endcase
   end

   // A HALT in the slot suppresses its own write, as does an earlier halt;
   // writes to r0 are dropped here so the register bank never sees them
   assign w_write_enable = i_instr_valid & i_reg_write & (i_rd_sel != '0)
                         & ~i_halt & ~r_halt;
   assign w_retire       = i_instr_valid & ~r_halt;

   // Write-port, halt and retire-counter registers, advanced only on accept
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_data         <= '0;
         r_sel          <= '0;
         r_write_enable <= 1'b0;
         r_halt         <= 1'b0;
         r_count        <= '0;
      end else if (i_valid) begin
         r_data         <= w_result;
         r_sel          <= i_rd_sel;
         r_write_enable <= w_write_enable;
         if (i_instr_valid && i_halt) begin
            r_halt <= 1'b1;
         end
         if (w_retire) begin
            r_count <= r_count + NB_COUNT'(1);
         end
      end
   end

   // Outputs come straight from flops; decode samples them on the falling edge
   assign o_data_reg_write     = r_data;
   assign o_data_reg_write_sel = r_sel;
   assign o_write_reg_enable   = r_write_enable;
   assign o_halt               = r_halt;
   assign o_retired_count      = r_count;

endmodule : writeback_stage
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_writeback_stage
//  Description : Self-checking bench for writeback_stage. A behavioural model
//                tracks the expected write port, halt flag and retire count;
//                a falling-edge compare process checks both a 32-bit-counter
//                and a 4-bit-counter instance against it every cycle, plus
//                hand-computed literal expectations for directed scenarios.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_stage;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        i_reset;
   logic        i_valid;
   logic        i_instr_valid;
   logic        i_reg_write;
   logic [1:0]  i_wb_src;
   logic [1:0]  i_load_size;
   logic        i_load_unsigned;
   logic        i_halt;
   logic [4:0]  i_rd_sel;
   logic [31:0] i_alu_result;
   logic [31:0] i_mem_data;
   logic [31:0] i_pc_next;

   logic [31:0] o_data;
   logic [4:0]  o_sel;
   logic        o_we;
   logic        o_halt;
   logic [31:0] o_count;

   logic [31:0] o4_data;
   logic [4:0]  o4_sel;
   logic        o4_we;
   logic        o4_halt;
   logic [3:0]  o4_count;

   writeback_stage #(.NB_DATA(32), .NB_REGISTER(5), .NB_COUNT(32)) dut (
      .i_clock              (clk),
      .i_reset              (i_reset),
      .i_valid              (i_valid),
      .i_instr_valid        (i_instr_valid),
      .i_reg_write          (i_reg_write),
      .i_wb_src             (i_wb_src),
      .i_load_size          (i_load_size),
      .i_load_unsigned      (i_load_unsigned),
      .i_halt               (i_halt),
      .i_rd_sel             (i_rd_sel),
      .i_alu_result         (i_alu_result),
      .i_mem_data           (i_mem_data),
      .i_pc_next            (i_pc_next),
      .o_data_reg_write     (o_data),
      .o_data_reg_write_sel (o_sel),
      .o_write_reg_enable   (o_we),
      .o_halt               (o_halt),
      .o_retired_count      (o_count)
   );

   writeback_stage #(.NB_DATA(32), .NB_REGISTER(5), .NB_COUNT(4)) dut4 (
      .i_clock              (clk),
      .i_reset              (i_reset),
      .i_valid              (i_valid),
      .i_instr_valid        (i_instr_valid),
      .i_reg_write          (i_reg_write),
      .i_wb_src             (i_wb_src),
      .i_load_size          (i_load_size),
      .i_load_unsigned      (i_load_unsigned),
      .i_halt               (i_halt),
      .i_rd_sel             (i_rd_sel),
      .i_alu_result         (i_alu_result),
      .i_mem_data           (i_mem_data),
      .i_pc_next            (i_pc_next),
      .o_data_reg_write     (o4_data),
      .o_data_reg_write_sel (o4_sel),
      .o_write_reg_enable   (o4_we),
      .o_halt               (o4_halt),
      .o_retired_count      (o4_count)
   );

   // Behavioural model state
   logic [31:0] m_data;
   logic [4:0]  m_sel;
   logic        m_we;
   logic        m_halt;
   logic [31:0] m_count;

   // Literal expectations for directed steps
   logic        exp_en = 1'b0;
   logic [31:0] exp_data;
   logic [4:0]  exp_sel;
   logic        exp_we;
   logic        exp_halt;
   logic [31:0] exp_count;

   logic        chk_on = 1'b0;
   int          n_tests = 0;
   int          n_fail  = 0;

   // Load result from the rules: shift the addressed lane down, mask, extend
   function automatic logic [31:0] m_load(logic [31:0] w, logic [1:0] a,
                                          logic [1:0] sz, logic u);
      logic [31:0] v;
      int          bits;
      if (sz == 2'd0) begin
         v    = (w >> (8 * a)) & 32'h0000_00FF;
         bits = 8;
      end else if (sz == 2'd1) begin
         v    = (w >> (16 * a[1])) & 32'h0000_FFFF;
         bits = 16;
      end else begin
         return w;
      end
      if (!u && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Compare both instances against the model on every falling edge
   always @(negedge clk) begin
      if (chk_on) begin
         chk("data",   o_data,           m_data);
         chk("sel",    {27'd0, o_sel},   {27'd0, m_sel});
         chk("we",     {31'd0, o_we},    {31'd0, m_we});
         chk("halt",   {31'd0, o_halt},  {31'd0, m_halt});
         chk("count",  o_count,          m_count);
         chk("data4",  o4_data,          m_data);
         chk("we4",    {31'd0, o4_we},   {31'd0, m_we});
         chk("halt4",  {31'd0, o4_halt}, {31'd0, m_halt});
         chk("count4", {28'd0, o4_count}, {28'd0, m_count[3:0]});
         if (exp_en) begin
            chk("lit_data",   o_data,              exp_data);
            chk("lit_sel",    {27'd0, o_sel},      {27'd0, exp_sel});
            chk("lit_we",     {31'd0, o_we},       {31'd0, exp_we});
            chk("lit_halt",   {31'd0, o_halt},     {31'd0, exp_halt});
            chk("lit_count",  o_count,             exp_count);
            chk("lit_count4", {28'd0, o4_count},   {28'd0, exp_count[3:0]});
            chk("model_data",  m_data,  exp_data);
            chk("model_count", m_count, exp_count);
         end
      end
   end

   task automatic model_clear();
      m_data  = '0;
      m_sel   = '0;
      m_we    = 1'b0;
      m_halt  = 1'b0;
      m_count = '0;
   endtask

   // Advance the model by one rising edge using the inputs currently applied
   task automatic model_step();
      logic [31:0] r;
      if (i_valid) begin
         case (i_wb_src)
            2'd1:    r = m_load(i_mem_data, i_alu_result[1:0], i_load_size, i_load_unsigned);
            2'd2:    r = i_pc_next;
            default: r = i_alu_result;
         endcase
         m_data = r;
         m_sel  = i_rd_sel;
         m_we   = i_instr_valid && i_reg_write && (i_rd_sel != 5'd0) && !m_halt && !i_halt;
         if (i_instr_valid && !m_halt) m_count = m_count + 32'd1;
         if (i_instr_valid && i_halt)  m_halt  = 1'b1;
      end
   endtask

   // Apply one slot at posedge+1, clock it in, then return to idle (i_valid=0)
   task automatic drive(input logic v, input logic iv, input logic rw,
                        input logic [1:0] src, input logic [1:0] sz, input logic u,
                        input logic h, input logic [4:0] rd, input logic [31:0] alu,
                        input logic [31:0] mem, input logic [31:0] pc);
      i_valid         = v;
      i_instr_valid   = iv;
      i_reg_write     = rw;
      i_wb_src        = src;
      i_load_size     = sz;
      i_load_unsigned = u;
      i_halt          = h;
      i_rd_sel        = rd;
      i_alu_result    = alu;
      i_mem_data      = mem;
      i_pc_next       = pc;
      @(posedge clk);
      model_step();
      #1;
      i_valid = 1'b0;
   endtask

   // Check literals at the next falling edge, then idle one more cycle
   task automatic expect_lit(input logic [31:0] d, input logic [4:0] s,
                             input logic we, input logic h, input logic [31:0] c);
      exp_data  = d;
      exp_sel   = s;
      exp_we    = we;
      exp_halt  = h;
      exp_count = c;
      exp_en    = 1'b1;
      @(negedge clk);
      #1 exp_en = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_reset = 1'b1;
      i_valid = 1'b0;
      model_clear();
      @(posedge clk);
      #1;
      i_reset = 1'b0;
   endtask

   task automatic alu_wr(input logic [4:0] rd, input logic [31:0] val);
      drive(1, 1, 1, 2'd0, 2'd2, 0, 0, rd, val, 32'd0, 32'd0);
   endtask

   initial begin
      i_reset = 1'b1;
      i_valid = 1'b0; i_instr_valid = 1'b0; i_reg_write = 1'b0;
      i_wb_src = 2'd0; i_load_size = 2'd0; i_load_unsigned = 1'b0; i_halt = 1'b0;
      i_rd_sel = 5'd0; i_alu_result = '0; i_mem_data = '0; i_pc_next = '0;
      model_clear();
      @(posedge clk);
      #1 chk_on = 1'b1;
      // Reset state, held across a falling edge
      expect_lit(32'h0, 5'd0, 0, 0, 32'd0);
      i_reset = 1'b0;

      // Byte loads from lane 3, signed then unsigned
      drive(1, 1, 1, 2'd1, 2'd0, 0, 0, 5'd8, 32'd3, 32'h80FF_7F01, 32'd0);
      expect_lit(32'hFFFF_FF80, 5'd8, 1, 0, 32'd1);
      drive(1, 1, 1, 2'd1, 2'd0, 1, 0, 5'd8, 32'd3, 32'h80FF_7F01, 32'd0);
      expect_lit(32'h0000_0080, 5'd8, 1, 0, 32'd2);

      // Halfword loads: upper half signed, a[0] ignored, lower half unsigned
      drive(1, 1, 1, 2'd1, 2'd1, 0, 0, 5'd9, 32'd2, 32'h8001_ABCD, 32'd0);
      expect_lit(32'hFFFF_8001, 5'd9, 1, 0, 32'd3);
      drive(1, 1, 1, 2'd1, 2'd1, 0, 0, 5'd9, 32'd3, 32'h8001_ABCD, 32'd0);
      expect_lit(32'hFFFF_8001, 5'd9, 1, 0, 32'd4);
      drive(1, 1, 1, 2'd1, 2'd1, 1, 0, 5'd9, 32'd0, 32'h8001_ABCD, 32'd0);
      expect_lit(32'h0000_ABCD, 5'd9, 1, 0, 32'd5);

      // Link writes: r31 enabled, r0 suppressed
      drive(1, 1, 1, 2'd2, 2'd2, 0, 0, 5'd31, 32'h1234, 32'd0, 32'h48);
      expect_lit(32'h48, 5'd31, 1, 0, 32'd6);
      drive(1, 1, 1, 2'd2, 2'd2, 0, 0, 5'd0, 32'h1234, 32'd0, 32'h48);
      expect_lit(32'h48, 5'd0, 0, 0, 32'd7);

      // Three ALU writes, four stalled cycles, then a bubble
      do_reset();
      alu_wr(5'd1, 32'hA);
      alu_wr(5'd2, 32'hB);
      alu_wr(5'd3, 32'hC);
      for (int k = 0; k < 4; k++) expect_lit(32'hC, 5'd3, 1, 0, 32'd3);
      drive(1, 0, 1, 2'd0, 2'd2, 0, 0, 5'd5, 32'h55, 32'd0, 32'd0);
      expect_lit(32'h55, 5'd5, 0, 0, 32'd3);

      // HALT with reg_write: halt wins, counted once, then everything frozen
      do_reset();
      alu_wr(5'd1, 32'h11);
      drive(1, 1, 1, 2'd0, 2'd2, 0, 1, 5'd4, 32'h44, 32'd0, 32'd0);
      expect_lit(32'h44, 5'd4, 0, 1, 32'd2);
      for (int k = 0; k < 5; k++) begin
         alu_wr(5'd6, 32'h60 + k);
         expect_lit(32'h60 + k, 5'd6, 0, 1, 32'd2);
      end
      // Asynchronous reset mid-cycle, before the next rising edge
      #2 i_reset = 1'b1;
      model_clear();
      expect_lit(32'h0, 5'd0, 0, 0, 32'd0);
      i_reset = 1'b0;

      // Sixteen retirements: the 4-bit counter wraps to 0
      for (int k = 0; k < 16; k++) alu_wr(5'(k + 1), 32'(k));
      expect_lit(32'd15, 5'd16, 1, 0, 32'd16);

      // Randomized traffic with occasional halts and resets
      do_reset();
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 149) == 0) begin
            do_reset();
         end else begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom),
                  2'($urandom), 2'($urandom), 1'($urandom),
                  $urandom_range(0, 59) == 0, 5'($urandom),
                  $urandom, $urandom, $urandom);
         end
      end
      @(negedge clk);
      #1 chk_on = 1'b0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_writeback_stage
`default_nettype wire

// File: doc/writeback_stage.md
# writeback_stage

Final stage of the MIPS pipeline and the producer side of the decode stage's register-write port. Each accepted cycle it selects the result (ALU, aligned and extended load data, or link address), registers it and drives the register-bank write port: data, select and enable. It also latches a sticky halt flag when a HALT instruction retires and keeps a retired-instruction counter for the debug unit.

## Interface
- NB_DATA, 32, datapath width
- NB_REGISTER, 5, register select width
- NB_COUNT, 32, retired-counter width
- i_clock  in  1  pipeline clock, all state on rising edge
- i_reset  in  1  asynchronous, active-high; clears all state
- i_valid  in  1  pipeline advance enable (step/run from debug unit); state updates only when 1
- i_instr_valid  in  1  slot holds a real instruction (0 = bubble)
- i_reg_write  in  1  instruction writes a GPR
- i_wb_src  in  2  result source: ALU / MEM / LINK
- i_load_size  in  2  BYTE / HALF / WORD
- i_load_unsigned  in  1  zero-extend (1) or sign-extend (0) sub-word loads
- i_halt  in  1  instruction is HALT
- i_rd_sel  in  NB_REGISTER  destination register
- i_alu_result  in  NB_DATA  ALU result; bits [1:0] are also the load byte address
- i_mem_data  in  NB_DATA  word read from data memory
- i_pc_next  in  NB_DATA  link address for JAL/JALR
- o_data_reg_write  out  NB_DATA  write data to register bank
- o_data_reg_write_sel  out  NB_REGISTER  write select
- o_write_reg_enable  out  1  write enable
- o_halt  out  1  sticky halt
- o_retired_count  out  NB_COUNT  retired instructions

## Operation
- Accept condition: i_valid=1. When i_valid=0 all outputs and state hold.
- Source mux: ALU → i_alu_result; LINK → i_pc_next; MEM → aligned load; code 11 is treated as ALU.
- Load alignment is little-endian, with a = i_alu_result[1:0]:
  - BYTE: lane i_mem_data[8a+7:8a].
  - HALF: lane selected by a[1] only, lower half when a[1]=0; a[0] ignored, no exception.
  - WORD and size code 11: full word, a ignored.
  - Sub-word result is extended to NB_DATA per i_load_unsigned.
- Write enable registered as i_instr_valid & i_reg_write & (i_rd_sel≠0) & ~halted. Data and select always register on accept.
- Halt: on accept with i_instr_valid & i_halt, o_halt sets and stays 1 until reset. The HALT itself never writes a GPR.
- After halt: o_write_reg_enable forced 0 on every later accept; counter frozen.
- Counter: +1 on each accept with i_instr_valid=1 while not yet halted, HALT included. Wraps 2^NB_COUNT−1 → 0.

## Timing
- Latency 1: values accepted at rising edge k appear on outputs after edge k, stable for the full cycle.
- The decode stage samples data on the falling edge, so outputs must be direct register outputs with no combinational path to output.
- o_halt rises the cycle after the HALT is accepted. The counter includes HALT in that same cycle.
- Reset (async, any time, including mid-run or while halted): o_data_reg_write=0, o_data_reg_write_sel=0, o_write_reg_enable=0, o_halt=0, o_retired_count=0. First accept after release behaves normally.
- Simultaneous HALT with i_reg_write=1: halt wins, no write.
- Bubble (i_instr_valid=0) on accept: enable=0, count unchanged; data/select still update.

## Structure
- Shared package mips_pkg holds:
  - WB_SRC_ALU=2'b00, WB_SRC_MEM=2'b01, WB_SRC_LINK=2'b10.
  - LOAD_BYTE=2'b00, LOAD_HALF=2'b01, LOAD_WORD=2'b10.
  - The decode/control stages use the same constants.
- One combinational sub-module, load_aligner: lane selection plus extension, inputs word, addr[1:0], size, unsigned. It is reused by the debug memory viewer.
- Top holds the source mux, output registers, halt flag and counter.

## Test plan
- MEM LOAD_BYTE signed, i_mem_data=0x80FF7F01, addr 3, rd=8, accept → next cycle data=0xFFFFFF80, sel=8, enable=1; unsigned variant → 0x00000080.
- MEM LOAD_HALF signed, i_mem_data=0x8001ABCD, addr 2 → 0xFFFF8001; addr 3 → same (a[0] ignored); addr 0 unsigned → 0x0000ABCD.
- LINK with rd=31, i_pc_next=0x00000048 → data=0x48, sel=31, enable=1; repeat with rd=0 → enable=0.
- Three valid ALU writes, then i_valid=0 for 4 cycles → outputs unchanged, count=3; bubble accept → enable=0, count=3.
- HALT with i_reg_write=1 accepted → o_halt=1 next cycle, enable=0, count +1. Then 5 more valid instructions → enable stays 0, count frozen. Async reset mid-cycle → all outputs 0 immediately.
- Counter preloaded via NB_COUNT=4: 16 valid instructions from reset → count wraps to 0.
